fsm_mestre_cq: RTL and testbench

FSM_MESTRE_CQ -- requirements
Module: fsm_mestre_cq

---
 rtl/fsm_mestre_cq_if.sv | 32 +++
 rtl/fsm_mestre_cq.sv | 119 +++++++++++
 tb/tb_fsm_mestre_cq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fsm_mestre_cq_if.sv
// Handshake bundle between the line master FSM and its environment
// (operator controls, QC position sensor and the QC/discard block).
interface fsm_mestre_cq_if;
   logic       habilitar;
   logic       sensor_cq;
   logic       cq_idle;
   logic       cq_tarefa_concluida;
   logic       cq_garrafa_aprovada;
   logic       limpar_contagem;
   logic       ack_erro;
   logic       cq_start;
   logic       cq_garrafa_concluida;
   logic       esteira_ativa;
   logic [3:0] contador_garrafas;
   logic [6:0] duzias;
   logic       duzia_completa;
   logic       erro_timeout;

   modport master (
      input  habilitar, sensor_cq, cq_idle, cq_tarefa_concluida,
             cq_garrafa_aprovada, limpar_contagem, ack_erro,
      output cq_start, cq_garrafa_concluida, esteira_ativa,
             contador_garrafas, duzias, duzia_completa, erro_timeout
   );

   modport slave (
      output habilitar, sensor_cq, cq_idle, cq_tarefa_concluida,
             cq_garrafa_aprovada, limpar_contagem, ack_erro,
      input  cq_start, cq_garrafa_concluida, esteira_ativa,
             contador_garrafas, duzias, duzia_completa, erro_timeout
   );
endinterface

// File: rtl/fsm_mestre_cq.sv
// Bottling line master: moves bottles to QC, waits for the verdict with a
// timeout, releases them and counts approved bottles in dozens.
//
// state          | meaning
// IDLE           | line stopped, waiting for enable and QC idle
// ESPERA_GARRAFA | conveyor running, waiting for a bottle at QC
// AGUARDA_CQ     | conveyor stopped, QC started, timeout running
// FINALIZA       | verdict in, bottle released to QC/discard until it is idle
// LIBERA         | conveyor running until the bottle leaves the sensor
// ERRO           | QC timed out, waiting for operator acknowledge
module fsm_mestre_cq #(
   parameter logic [25:0] TIMEOUT_CICLOS = 26'd50000000,
   parameter logic [6:0]  MAX_DUZIAS     = 7'd99
) (
   input logic             clk,
   input logic             reset,
   fsm_mestre_cq_if.master bus
);

   typedef enum logic [2:0] {
      IDLE           = 3'd0,
      ESPERA_GARRAFA = 3'd1,
      AGUARDA_CQ     = 3'd2,
      FINALIZA       = 3'd3,
      LIBERA         = 3'd4,
      ERRO           = 3'd5
   } estado_t;

   estado_t     estado_q, estado_d;
   logic [25:0] timer_q, timer_d;
   logic [3:0]  contador_q, contador_d;
   logic [6:0]  duzias_q, duzias_d;
   logic        pulso_q, pulso_d;
   logic        incrementa;
   logic        timeout;

   assign timeout = (timer_q == TIMEOUT_CICLOS - 26'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         estado_q   <= IDLE;
         timer_q    <= '0;
         contador_q <= '0;
         duzias_q   <= '0;
         pulso_q    <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         timer_q    <= timer_d;
         contador_q <= contador_d;
         duzias_q   <= duzias_d;
         pulso_q    <= pulso_d;
      end
   end

   // A verdict arriving on the last timeout cycle still takes the FINALIZA path.
   always_comb begin
      estado_d   = estado_q;
      incrementa = 1'b0;
      case (estado_q)
         IDLE: begin
            if (bus.habilitar && bus.cq_idle) estado_d = ESPERA_GARRAFA;
         end
         ESPERA_GARRAFA: begin
            if (bus.sensor_cq)       estado_d = AGUARDA_CQ;
            else if (!bus.habilitar) estado_d = IDLE;
         end
         AGUARDA_CQ: begin
            if (bus.cq_tarefa_concluida) begin
               estado_d   = FINALIZA;
               incrementa = bus.cq_garrafa_aprovada;
            end else if (timeout) begin
               estado_d = ERRO;
            end
         end
         FINALIZA: begin
            if (bus.cq_idle) estado_d = LIBERA;
         end
         LIBERA: begin
            if (!bus.sensor_cq) estado_d = bus.habilitar ? ESPERA_GARRAFA : IDLE;
         end
         ERRO: begin
            if (bus.ack_erro) estado_d = IDLE;
         end
         default: estado_d = IDLE;
      endcase
   end

   always_comb begin
      timer_d = '0;
      if (estado_q == AGUARDA_CQ && estado_d == AGUARDA_CQ) timer_d = timer_q + 26'd1;
   end

   always_comb begin
      contador_d = contador_q;
      duzias_d   = duzias_q;
      pulso_d    = 1'b0;
      if (bus.limpar_contagem) begin
         contador_d = '0;
         duzias_d   = '0;
      end else if (incrementa) begin
         if (contador_q == 4'd11) begin
            contador_d = '0;
            pulso_d    = 1'b1;
            if (duzias_q != MAX_DUZIAS) duzias_d = duzias_q + 7'd1;
         end else begin
            contador_d = contador_q + 4'd1;
         end
      end
   end

   assign bus.cq_start             = (estado_q == AGUARDA_CQ);
   assign bus.cq_garrafa_concluida = (estado_q == FINALIZA);
   assign bus.esteira_ativa        = (estado_q == ESPERA_GARRAFA) || (estado_q == LIBERA);
   assign bus.erro_timeout         = (estado_q == ERRO);
   assign bus.contador_garrafas    = contador_q;
   assign bus.duzias               = duzias_q;
   assign bus.duzia_completa       = pulso_q;

endmodule

// File: tb/tb_fsm_mestre_cq.sv
// Scoreboard bench for fsm_mestre_cq: expected counts are queued when a
// verdict is driven and checked when the FSM enters FINALIZA.
module tb_fsm_mestre_cq;

   typedef struct {
      int cnt;
      int duz;
      int pulso;
   } esperado_t;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;
   int   exp_cnt;
   int   exp_duz;
   int   pulsos_exp;
   int   pulsos_vistos;
   bit   gc_ant;
   esperado_t sb_q[$];

   fsm_mestre_cq_if bus ();

   fsm_mestre_cq #(
      .TIMEOUT_CICLOS(26'd20),
      .MAX_DUZIAS    (7'd99)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Scoreboard consumer: FINALIZA entry is when the count update is visible.
   always @(negedge clk) begin
      esperado_t e;
      pulsos_vistos += int'(bus.duzia_completa);
      if (reset) begin
         gc_ant = 1'b0;
      end else begin
         if (bus.cq_garrafa_concluida && !gc_ant) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_unexpected_verdict", 0, 1);
            end else begin
               e = sb_q.pop_front();
               check_eq("sb_contador", int'(bus.contador_garrafas), e.cnt);
               check_eq("sb_duzias", int'(bus.duzias), e.duz);
               check_eq("sb_pulso", int'(bus.duzia_completa), e.pulso);
            end
         end
         gc_ant = bus.cq_garrafa_concluida;
      end
   end

   task automatic push_modelo(input bit aprov, input bit limpar);
      esperado_t e;
      e.pulso = 0;
      if (limpar) begin
         exp_cnt = 0;
         exp_duz = 0;
      end else if (aprov) begin
         if (exp_cnt == 11) begin
            exp_cnt = 0;
            e.pulso = 1;
            if (exp_duz < 99) exp_duz++;
         end else begin
            exp_cnt++;
         end
      end
      pulsos_exp += e.pulso;
      e.cnt = exp_cnt;
      e.duz = exp_duz;
      sb_q.push_back(e);
   endtask

   task automatic wait_start(output bit ok);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!bus.cq_start && n < 5);
      ok = bus.cq_start;
      if (!ok) check_eq("start_wait_expired", 0, 1);
   endtask

   // Starts and ends in ESPERA_GARRAFA (or IDLE->ESPERA when hab_drop).
   task automatic run_bottle(input bit aprov, input int vd, input int idle_d,
                             input bit limpar, input bit hab_drop);
      int n;
      bit ok;
      bus.sensor_cq = 1'b1;
      wait_start(ok);
      if (!ok) begin
         bus.sensor_cq = 1'b0;
         return;
      end
      bus.cq_idle = 1'b0;
      if (hab_drop) bus.habilitar = 1'b0;
      n = 1;
      for (int i = 1; i < vd; i++) begin
         tick();
         n += int'(bus.cq_start);
      end
      check_eq("start_len", n, vd);
      bus.cq_tarefa_concluida = 1'b1;
      bus.cq_garrafa_aprovada = aprov;
      bus.limpar_contagem     = limpar;
      push_modelo(aprov, limpar);
      tick();
      bus.cq_tarefa_concluida = 1'b0;
      bus.cq_garrafa_aprovada = 1'b0;
      bus.limpar_contagem     = 1'b0;
      check_eq("fin_start", int'(bus.cq_start), 0);
      check_eq("fin_belt", int'(bus.esteira_ativa), 0);
      check_eq("fin_erro", int'(bus.erro_timeout), 0);
      n = int'(bus.cq_garrafa_concluida);
      for (int i = 1; i < idle_d; i++) begin
         tick();
         n += int'(bus.cq_garrafa_concluida);
      end
      check_eq("gc_len", n, idle_d);
      bus.cq_idle = 1'b1;
      tick();
      check_eq("lib_gc", int'(bus.cq_garrafa_concluida), 0);
      check_eq("lib_belt", int'(bus.esteira_ativa), 1);
      bus.sensor_cq = 1'b0;
      tick();
      check_eq("after_lib_belt", int'(bus.esteira_ativa), hab_drop ? 0 : 1);
      if (hab_drop) begin
         bus.habilitar = 1'b1;
         tick();
         check_eq("reenable_belt", int'(bus.esteira_ativa), 1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_start"}, int'(bus.cq_start), 0);
      check_eq({tag, "_gc"}, int'(bus.cq_garrafa_concluida), 0);
      check_eq({tag, "_belt"}, int'(bus.esteira_ativa), 0);
      check_eq({tag, "_cnt"}, int'(bus.contador_garrafas), 0);
      check_eq({tag, "_duz"}, int'(bus.duzias), 0);
      check_eq({tag, "_pulso"}, int'(bus.duzia_completa), 0);
      check_eq({tag, "_erro"}, int'(bus.erro_timeout), 0);
   endtask

   initial begin
      int  n;
      bit  ok;
      n_checks      = 0;
      n_errors      = 0;
      exp_cnt       = 0;
      exp_duz       = 0;
      pulsos_exp    = 0;
      pulsos_vistos = 0;
      gc_ant        = 1'b0;
      reset                   = 1'b1;
      bus.habilitar           = 1'b0;
      bus.sensor_cq           = 1'b0;
      bus.cq_idle             = 1'b0;
      bus.cq_tarefa_concluida = 1'b0;
      bus.cq_garrafa_aprovada = 1'b0;
      bus.limpar_contagem     = 1'b0;
      bus.ack_erro            = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check_eq("idle_belt", int'(bus.esteira_ativa), 0);
      bus.habilitar = 1'b1;
      bus.cq_idle   = 1'b1;
      tick();
      check_eq("espera_belt", int'(bus.esteira_ativa), 1);

      run_bottle(1'b1, 3, 2, 1'b0, 1'b0);
      run_bottle(1'b0, 2, 10, 1'b0, 1'b0);
      run_bottle(1'b1, 1, 1, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) run_bottle(1'b1, 1, 2, 1'b0, 1'b0);
      check_eq("dozen_cnt", int'(bus.contador_garrafas), 0);
      check_eq("dozen_duz", int'(bus.duzias), 1);

      // Timeout: no verdict for the full window.
      bus.sensor_cq = 1'b1;
      wait_start(ok);
      bus.cq_idle = 1'b0;
      n = 1;
      for (int i = 0; i < 40 && bus.cq_start; i++) begin
         tick();
         n += int'(bus.cq_start);
      end
      check_eq("timeout_len", n, 20);
      check_eq("erro_flag", int'(bus.erro_timeout), 1);
      check_eq("erro_start", int'(bus.cq_start), 0);
      check_eq("erro_belt", int'(bus.esteira_ativa), 0);
      repeat (3) tick();
      check_eq("erro_hold", int'(bus.erro_timeout), 1);
      bus.ack_erro  = 1'b1;
      bus.sensor_cq = 1'b0;
      bus.cq_idle   = 1'b1;
      tick();
      bus.ack_erro = 1'b0;
      check_eq("ack_erro_clear", int'(bus.erro_timeout), 0);
      check_eq("ack_idle_belt", int'(bus.esteira_ativa), 0);
      check_eq("ack_cnt_kept", int'(bus.contador_garrafas), exp_cnt);
      check_eq("ack_duz_kept", int'(bus.duzias), exp_duz);
      tick();
      check_eq("ack_espera_belt", int'(bus.esteira_ativa), 1);

      run_bottle(1'b1, 20, 1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) run_bottle(1'b1, 1, 1, 1'b0, 1'b0);
      check_eq("pre_clear_cnt", int'(bus.contador_garrafas), 11);
      run_bottle(1'b1, 1, 1, 1'b1, 1'b0);
      check_eq("clear_cnt", int'(bus.contador_garrafas), 0);
      check_eq("clear_duz", int'(bus.duzias), 0);

      for (int i = 0; i < 1188; i++) run_bottle(1'b1, 1, 1, 1'b0, 1'b0);
      check_eq("preload_duz", int'(bus.duzias), 99);
      for (int i = 0; i < 12; i++) run_bottle(1'b1, 1, 1, 1'b0, 1'b0);
      check_eq("sat_duz", int'(bus.duzias), 99);
      check_eq("sat_cnt", int'(bus.contador_garrafas), 0);

      // Reset while the bottle is in FINALIZA.
      bus.sensor_cq = 1'b1;
      wait_start(ok);
      bus.cq_idle             = 1'b0;
      bus.cq_tarefa_concluida = 1'b1;
      bus.cq_garrafa_aprovada = 1'b1;
      push_modelo(1'b1, 1'b0);
      tick();
      bus.cq_tarefa_concluida = 1'b0;
      bus.cq_garrafa_aprovada = 1'b0;
      check_eq("pre_reset_gc", int'(bus.cq_garrafa_concluida), 1);
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      exp_cnt = 0;
      exp_duz = 0;
      bus.sensor_cq = 1'b0;
      bus.cq_idle   = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      tick();
      check_eq("post_reset_belt", int'(bus.esteira_ativa), 1);
      check_eq("post_reset_cnt", int'(bus.contador_garrafas), 0);

      check_eq("pulse_total", pulsos_vistos, pulsos_exp);
      check_eq("sb_leftover", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
